// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mp3_pkg
// Purpose  : Shared SCI opcodes, register map, defaults and state encoding
//            for the MP3 decoder serial responder.
// Revision : 1.0 - initial release
// ============================================================================
package mp3_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;

  localparam logic [7:0] REG_MODE   = 8'h00;
  localparam logic [7:0] REG_BASS   = 8'h02;
  localparam logic [7:0] REG_CLOCKF = 8'h03;
  localparam logic [7:0] REG_VOL    = 8'h0B;

  localparam logic [15:0] c_modeDefault   = 16'h0800;
  localparam logic [15:0] c_bassDefault   = 16'h0000;
  localparam logic [15:0] c_clockfDefault = 16'h0000;
  localparam logic [15:0] c_volDefault    = 16'h0000;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_BOOT = 3'd1,
    ST_IDLE = 3'd2,
    ST_SCI  = 3'd3,
    ST_SDI  = 3'd4
  } state_t;

  // Unmapped addresses read back as zero.
  function automatic logic [15:0] regRead(input logic [7:0]  addr,
                                          input logic [15:0] mode,
                                          input logic [15:0] bass,
                                          input logic [15:0] clockf,
                                          input logic [15:0] vol);
    case (addr)
      REG_MODE:   return mode;
      REG_BASS:   return bass;
      REG_CLOCKF: return clockf;
      REG_VOL:    return vol;
      default:    return 16'h0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp3_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mp3_byte_fifo
// Purpose  : Synchronous byte FIFO with occupancy count and flush.
// Revision : 1.0 - initial release
// ============================================================================
module mp3_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == c_depth);
  assign w_doPop  = i_pop && !o_empty;
  // A push into a full FIFO is accepted when a pop frees the slot this cycle.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_count  = r_count;
  assign o_data   = o_empty ? 8'h00 : r_mem[r_rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/mp3_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : mp3_spi_slave
// Purpose  : MP3 decoder serial responder: SCI register frames, SDI audio
//            FIFO and DREQ flow control. Define MP3_SLAVE_READ_EN for SCI reads.
// Revision : 1.0 - initial release
// ============================================================================
module mp3_spi_slave
  import mp3_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int DREQ_ROOM   = 32,
  parameter int BOOT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MP3_SCLK,
  input  logic        MP3_MOSI,
  input  logic        MP3_xCS,
  input  logic        MP3_xDCS,
  input  logic        MP3_xRSET,
  output logic        MP3_MISO,
  output logic        MP3_DREQ,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic [15:0] MODE,
  output logic [15:0] BASS,
  output logic [15:0] CLOCKF,
  output logic [15:0] VOL,
  output logic        SCI_WR,
  output logic        OVERFLOW
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BOOT_CYCLES + 1);

  logic [1:0] r_sclkSync, r_mosiSync, r_xcsSync, r_xdcsSync, r_xrsetSync;
  logic       r_sclkDly;
  logic       w_sclk, w_mosi, w_xcs, w_xdcs, w_xrset, w_rise;

  state_t         r_state;
  logic [BW-1:0]  r_bootCnt;
  logic [5:0]     r_sciCnt;
  logic [31:0]    r_sciSh;
  logic           r_sciDone;
  logic [2:0]     r_sdiCnt;
  logic [7:0]     r_sdiSh;
  logic           r_push;
  logic [7:0]     r_pushData;
  logic [15:0]    r_mode, r_bass, r_clockf, r_vol;
  logic           r_sciWr, r_overflow, r_dreq;
  logic [CW:0]    w_count;
  logic           w_full, w_empty, w_active;

  assign w_sclk  = r_sclkSync[1];
  assign w_mosi  = r_mosiSync[1];
  assign w_xcs   = r_xcsSync[1];
  assign w_xdcs  = r_xdcsSync[1];
  assign w_xrset = r_xrsetSync[1];
  assign w_rise  = w_sclk && !r_sclkDly;
  assign w_active = (r_state == ST_IDLE) || (r_state == ST_SCI) || (r_state == ST_SDI);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sclkSync  <= 2'b00;
      r_mosiSync  <= 2'b00;
      r_xcsSync   <= 2'b11;
      r_xdcsSync  <= 2'b11;
      r_xrsetSync <= 2'b00;
      r_sclkDly   <= 1'b0;
    end else begin
      r_sclkSync  <= {r_sclkSync[0],  MP3_SCLK};
      r_mosiSync  <= {r_mosiSync[0],  MP3_MOSI};
      r_xcsSync   <= {r_xcsSync[0],   MP3_xCS};
      r_xdcsSync  <= {r_xdcsSync[0],  MP3_xDCS};
      r_xrsetSync <= {r_xrsetSync[0], MP3_xRSET};
      r_sclkDly   <= w_sclk;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_RST;
      r_bootCnt  <= '0;
      r_sciCnt   <= '0;
      r_sciSh    <= '0;
      r_sciDone  <= 1'b0;
      r_sdiCnt   <= '0;
      r_sdiSh    <= '0;
      r_push     <= 1'b0;
      r_pushData <= '0;
      r_mode     <= c_modeDefault;
      r_bass     <= c_bassDefault;
      r_clockf   <= c_clockfDefault;
      r_vol      <= c_volDefault;
      r_sciWr    <= 1'b0;
      r_overflow <= 1'b0;
      r_dreq     <= 1'b0;
    end else begin
      r_sciWr   <= 1'b0;
      r_sciDone <= 1'b0;
      r_push    <= 1'b0;
      r_dreq    <= w_active && ((FIFO_DEPTH - int'(w_count)) >= DREQ_ROOM);

      case (r_state)
        ST_RST: begin
          r_mode     <= c_modeDefault;
          r_bass     <= c_bassDefault;
          r_clockf   <= c_clockfDefault;
          r_vol      <= c_volDefault;
          r_overflow <= 1'b0;
          r_bootCnt  <= '0;
          if (w_xrset) r_state <= ST_BOOT;
        end
        ST_BOOT: begin
          r_bootCnt <= r_bootCnt + 1'b1;
          if (r_bootCnt == BW'(BOOT_CYCLES - 1)) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!w_xcs)       r_state <= ST_SCI;
          else if (!w_xdcs) r_state <= ST_SDI;
        end
        ST_SCI: if (w_xcs) r_state <= ST_IDLE;
        // SCI pre-empts an open SDI stream.
        ST_SDI: if (w_xdcs || !w_xcs) r_state <= ST_IDLE;
        default: r_state <= ST_RST;
      endcase
      if (!w_xrset) r_state <= ST_RST;

      if (w_xcs || r_state != ST_SCI) begin
        r_sciCnt <= '0;
      end else if (w_rise && r_sciCnt < 6'd32) begin
        r_sciSh   <= {r_sciSh[30:0], w_mosi};
        r_sciCnt  <= r_sciCnt + 1'b1;
        r_sciDone <= (r_sciCnt == 6'd31);
      end

      if (w_xdcs || r_state != ST_SDI) begin
        r_sdiCnt <= '0;
      end else if (w_rise) begin
        r_sdiSh  <= {r_sdiSh[6:0], w_mosi};
        r_sdiCnt <= r_sdiCnt + 1'b1;
        if (r_sdiCnt == 3'd7) begin
          r_push     <= 1'b1;
          r_pushData <= {r_sdiSh[6:0], w_mosi};
        end
      end

      // Commit lands one cycle after the final bit is shifted in.
      if (r_sciDone && r_state != ST_RST && r_sciSh[31:24] == OP_WRITE) begin
        case (r_sciSh[23:16])
          REG_MODE:   begin r_mode   <= r_sciSh[15:0]; r_sciWr <= 1'b1; end
          REG_BASS:   begin r_bass   <= r_sciSh[15:0]; r_sciWr <= 1'b1; end
          REG_CLOCKF: begin r_clockf <= r_sciSh[15:0]; r_sciWr <= 1'b1; end
          REG_VOL:    begin r_vol    <= r_sciSh[15:0]; r_sciWr <= 1'b1; end
          default:    r_sciWr <= 1'b0;
        endcase
      end

      if (r_push && w_full && !DATA_READY && r_state != ST_RST) r_overflow <= 1'b1;
    end
  end

  mp3_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_flush (r_state == ST_RST),
    .i_push  (r_push),
    .i_data  (r_pushData),
    .i_pop   (DATA_READY),
    .o_data  (DATA_OUT),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef MP3_SLAVE_READ_EN
  logic        w_fall;
  logic        r_miso;
  logic        r_rdAct;
  logic [15:0] r_misoSh;
  logic [15:0] w_rdData;

  assign w_fall   = !w_sclk && r_sclkDly;
  assign w_rdData = regRead(r_sciSh[7:0], r_mode, r_bass, r_clockf, r_vol);

  // After 16 bits the low shift-register bytes hold the opcode and address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_miso   <= 1'b0;
      r_rdAct  <= 1'b0;
      r_misoSh <= '0;
    end else if (w_xcs || r_state != ST_SCI) begin
      r_miso  <= 1'b0;
      r_rdAct <= 1'b0;
    end else if (w_fall) begin
      if (r_sciCnt == 6'd16) begin
        r_rdAct  <= (r_sciSh[15:8] == OP_READ);
        r_miso   <= (r_sciSh[15:8] == OP_READ) && w_rdData[15];
        r_misoSh <= {w_rdData[14:0], 1'b0};
      end else if (r_rdAct && r_sciCnt > 6'd16 && r_sciCnt < 6'd32) begin
        r_miso   <= r_misoSh[15];
        r_misoSh <= {r_misoSh[14:0], 1'b0};
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign MP3_MISO = r_miso;
`else
  assign MP3_MISO = 1'b0;
`endif

  assign MP3_DREQ   = r_dreq;
  assign DATA_VALID = !w_empty;
  assign MODE       = r_mode;
  assign BASS       = r_bass;
  assign CLOCKF     = r_clockf;
  assign VOL        = r_vol;
  assign SCI_WR     = r_sciWr;
  assign OVERFLOW   = r_overflow;

endmodule
`default_nettype wire
